// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus widths, broadcast record and functional-unit indices.
package cdb_arbiter_pkg;

    localparam int ROB_TAG_LEN = 5;
    localparam int XLEN        = 32;

    // Requester slot assignment on the arbiter's request vector
    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2
    } FU_IDX;

    // One result broadcast to the ROB and reservation stations
    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
    } CDB_DATA;

    localparam CDB_DATA CDB_IDLE = '{valid: 1'b0, rob_tag: '0, value: '0};

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid request at or after start_ptr, wrapping.
module cdb_arbiter_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    // Scan offsets from farthest to nearest so the nearest valid request overwrites the rest
    always_comb begin
        int c;
        c         = 0;
        grant_o   = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(start_ptr_i) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req_i[IDX_W'(c)]) begin
                grant_o              = '0;
                grant_o[IDX_W'(c)]   = 1'b1;
                win_idx_o            = IDX_W'(c);
                any_o                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among functional units, registered broadcast one cycle later,
// plus a saturating count of cycles with two or more requesters competing.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int REQ_IDX_LEN = $clog2(NUM_REQ),
    parameter int CNT_LEN     = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0][ROB_TAG_LEN-1:0]   req_rob_tag,
    input  logic [NUM_REQ-1:0][XLEN-1:0]          req_value,
    output logic [NUM_REQ-1:0]                    grant,
    output CDB_DATA                               cdb_data,
    output logic [CNT_LEN-1:0]                    conflict_count
);

    logic [REQ_IDX_LEN-1:0] rr_ptr_q, rr_ptr_d;
    CDB_DATA                cdb_q, cdb_d;
    logic [CNT_LEN-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [REQ_IDX_LEN-1:0] win_idx;
    logic                   pick_any;
    logic                   fire;
    logic                   contended;

    cdb_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_LEN)
    ) u_picker (
        .req_i       (req_valid),
        .start_ptr_i (rr_ptr_q),
        .grant_o     (pick_grant),
        .win_idx_o   (win_idx),
        .any_o       (pick_any)
    );

    // Flush and reset veto the picker; the pointer only moves on a real grant
    assign fire      = pick_any & ~flush & ~reset;
    assign grant     = fire ? pick_grant : '0;
    assign contended = $countones(req_valid) >= 2;

    // Next-state: pointer wraps by compare-and-zero so non-power-of-two counts never overrun
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cdb_d    = cdb_q;
        cdb_d.valid = 1'b0;
        if (fire) begin
            rr_ptr_d      = (win_idx == REQ_IDX_LEN'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            cdb_d.valid   = 1'b1;
            cdb_d.rob_tag = req_rob_tag[win_idx];
            cdb_d.value   = req_value[win_idx];
        end
        cnt_d = cnt_q;
        if (contended && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= CDB_IDLE;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cdb_data       = cdb_q;
    assign conflict_count = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench: stimulus computes expected grants/broadcasts from a round-robin model,
// a separate monitor pops expected broadcasts and compares them against the CDB.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 3;

    logic                            clock = 1'b0;
    logic                            reset = 1'b1;
    logic                            flush = 1'b0;
    logic [N-1:0]                    req_valid = '0;
    logic [N-1:0][ROB_TAG_LEN-1:0]   req_rob_tag = '0;
    logic [N-1:0][XLEN-1:0]          req_value = '0;
    logic [N-1:0]                    grant, grant4;
    CDB_DATA                         cdb_data, cdb4;
    logic [15:0]                     cc;
    logic [3:0]                      cc4;

    cdb_arbiter dut (
        .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid),
        .req_rob_tag(req_rob_tag), .req_value(req_value),
        .grant(grant), .cdb_data(cdb_data), .conflict_count(cc)
    );

    cdb_arbiter #(.CNT_LEN(4)) dut4 (
        .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid),
        .req_rob_tag(req_rob_tag), .req_value(req_value),
        .grant(grant4), .cdb_data(cdb4), .conflict_count(cc4)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                     cyc;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        val;
    } exp_t;
    exp_t sbq[$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Reference model state
    int           m_ptr  = 0;
    int           m_cnt  = 0;
    int           m_cnt4 = 0;
    logic [N-1:0] last_g = '0;

    logic [ROB_TAG_LEN-1:0] st_tag[N];
    logic [XLEN-1:0]        st_val[N];
    bit                     pend[N];

    function automatic void evaluate();
        logic [N-1:0] eg;
        int           w;
        logic [1:0]   wi;
        eg = '0;
        w  = -1;
        if (!reset && !flush)
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) eg[w] = 1'b1;
        chk("grant", 64'(grant), 64'(eg));
        chk("grant_cnt4_inst", 64'(grant4), 64'(eg));
        chk("conflict_count", 64'(cc), 64'(m_cnt));
        chk("conflict_count_sat4", 64'(cc4), 64'(m_cnt4));
        if (reset) begin
            m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if ($countones(req_valid) >= 2) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (w >= 0) begin
                wi = 2'(w);
                sbq.push_back('{cyc, req_rob_tag[wi], req_value[wi]});
                m_ptr = (w + 1) % N;
            end
        end
        last_g = eg;
    endfunction

    task automatic cycle_(input logic r, input logic f, input logic [N-1:0] v);
        @(posedge clock);
        #1;
        reset = r;
        flush = f;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_rob_tag[i] = st_tag[i];
            req_value[i]   = st_val[i];
        end
        @(negedge clock);
        evaluate();
    endtask

    // Monitor: every cycle the CDB must carry exactly the broadcast granted one cycle earlier
    initial begin
        exp_t e;
        bit   exp_v;
        forever begin
            @(posedge clock);
            #2;
            exp_v = (sbq.size() > 0) && (sbq[0].cyc == cyc - 1);
            chk("cdb_valid", 64'(cdb_data.valid), 64'(exp_v));
            chk("cdb4_valid", 64'(cdb4.valid), 64'(exp_v));
            if (exp_v) begin
                e = sbq.pop_front();
                chk("cdb_tag", 64'(cdb_data.rob_tag), 64'(e.tag));
                chk("cdb_value", 64'(cdb_data.value), 64'(e.val));
                chk("cdb4_tag", 64'(cdb4.rob_tag), 64'(e.tag));
                chk("cdb4_value", 64'(cdb4.value), 64'(e.val));
            end else if (sbq.size() > 0 && sbq[0].cyc < cyc - 1) begin
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        bit r, f;
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            st_tag[i] = '0; st_val[i] = '0; pend[i] = 1'b0;
        end

        cycle_(1, 0, 3'b000);
        cycle_(1, 0, 3'b000);

        // Single request right after reset
        st_tag[1] = 5'd5; st_val[1] = 32'hAB;
        cycle_(0, 0, 3'b010);
        cycle_(0, 0, 3'b000);
        cycle_(0, 0, 3'b000);

        // All three held for six cycles from pointer 0
        cycle_(1, 0, 3'b000);
        for (int i = 0; i < N; i++) begin
            st_tag[i] = ROB_TAG_LEN'(10 + i); st_val[i] = XLEN'(100 + i);
        end
        repeat (6) cycle_(0, 0, 3'b111);
        cycle_(0, 0, 3'b000);

        // Pointer at 1: requester 2 wins, requester 0 held then granted
        cycle_(1, 0, 3'b000);
        cycle_(0, 0, 3'b001);
        cycle_(0, 0, 3'b101);
        cycle_(0, 0, 3'b001);
        cycle_(0, 0, 3'b000);

        // Flush blocks grants, pointer stays put
        cycle_(0, 1, 3'b111);
        cycle_(0, 0, 3'b111);
        cycle_(0, 0, 3'b000);

        // Reset mid-stream
        cycle_(0, 0, 3'b111);
        cycle_(1, 0, 3'b111);
        cycle_(0, 0, 3'b111);
        cycle_(0, 0, 3'b000);

        // Randomized traffic honouring the hold rule
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (last_g[i] || !pend[i] || ((flush || reset) && ($urandom % 2 == 0))) begin
                    pend[i]   = ($urandom % 4) != 0;
                    st_tag[i] = ROB_TAG_LEN'($urandom);
                    st_val[i] = $urandom;
                end
            end
            for (int i = 0; i < N; i++) v[i] = pend[i];
            r = ($urandom % 64) == 0;
            f = ($urandom % 10) == 0;
            cycle_(r, f, v);
        end

        cycle_(0, 0, 3'b000);
        cycle_(0, 0, 3'b000);
        #3;
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_REQ functional-unit requesters: ALU, multiplier and load/store unit.
- Each cycle it grants at most one pending result by round-robin and registers it onto the CDB one cycle later.
- The registered output drives cdb_data for the ROB and the reservation stations.
- It also keeps a saturating count of contention cycles for performance analysis.

Parameters:
- NUM_REQ, 3, number of requesting functional units. Must be at least 2.
- REQ_IDX_LEN, $clog2(NUM_REQ), width of the round-robin pointer and requester index.
- CNT_LEN, 16, width of the contention counter.

Ports:
- clock  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  pipeline squash. Blocks all grants this cycle.
- req_valid  input  [NUM_REQ-1:0]  requester i holds a finished result.
- req_rob_tag  input  [NUM_REQ-1:0][`ROB_TAG_LEN-1:0]  ROB tag of requester i's result.
- req_value  input  [NUM_REQ-1:0][`XLEN-1:0]  result value, or store address, of requester i.
- grant  output  [NUM_REQ-1:0]  one-hot or zero. Combinational acceptance of requester i this cycle.
- cdb_data  output  CDB_DATA  registered broadcast with fields valid, rob_tag, value.
- conflict_count  output  [CNT_LEN-1:0]  cycles in which two or more requesters were valid.

Behaviour:
- Reset (synchronous): cdb_data <= '{FALSE, 0, 0}, rr_ptr <= 0, conflict_count <= 0. grant is 0 during the reset cycle.
- Handshake:
  - A requester asserts req_valid with a stable tag and value until it sees grant[i]=1 in the same cycle.
  - It may drop or replace the request in the following cycle.
  - An ungranted request must be held. The arbiter never drops a request it did not grant.
- Grant selection (combinational):
  - Search from index rr_ptr upward, wrapping modulo NUM_REQ.
  - The first i with req_valid[i] wins.
  - No grant if flush or reset is high, or if no request is valid.
- Latency:
  - A grant in cycle t gives cdb_data.valid=1 in cycle t+1, carrying that requester's rob_tag and value.
  - No grant in cycle t gives cdb_data.valid=0 in cycle t+1. rob_tag and value are then don't-care but held at their previous values.
- Pointer update: on a grant to requester i, rr_ptr <= (i+1) mod NUM_REQ. Otherwise rr_ptr is unchanged, including on flush.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles of first assertion, provided there is no flush.
- Wrap: for non-power-of-two NUM_REQ, rr_ptr never takes a value of NUM_REQ or above. Increment uses compare-and-zero, not bit truncation.
- Flush:
  - Suppresses grants in the flush cycle, so cdb_data.valid=0 in the next cycle.
  - A broadcast already registered before the flush still appears; flush does not kill it.
  - Requesters are responsible for dropping squashed requests.
- Contention counter:
  - Increments when popcount(req_valid) >= 2 and not reset.
  - Counts regardless of flush.
  - Saturates at 2^CNT_LEN-1. No wrap.
- Single-requester case: one valid request is granted immediately, whatever rr_ptr is.
- Back-to-back: the same requester may be granted in consecutive cycles if it is the only one valid. The CDB sustains one result per cycle.

Decomposition:
- CDB_DATA struct, `ROB_TAG_LEN and `XLEN stay in the shared sys_defs package.
- Add FU_IDX enum {FU_ALU=0, FU_MULT=1, FU_MEM=2} there.
- One natural sub-module: rr_picker. It is combinational: inputs are the request vector and the start pointer; outputs are the one-hot grant, the winner index and an any-grant bit.
- The arbiter wraps rr_picker with the output register, the pointer register and the counter.

Test Plan:
- Reset, then a single request: after reset, req_valid=3'b010, tag=5, value=0xAB in cycle 1 -> grant=3'b010 in cycle 1; cdb_data={1,5,0xAB} in cycle 2; rr_ptr=2.
- All three held valid for 6 cycles from rr_ptr=0 -> grants in order 0,1,2,0,1,2. cdb_data.valid=1 for 6 consecutive cycles with matching tags. conflict_count=6.
- Hold requirement: req 0 and req 2 valid, rr_ptr=1 -> req 2 is granted first. Req 0 is held and granted in the next cycle. No result is lost or duplicated on the CDB.
- Flush: all valid with flush=1 for one cycle -> grant=0; cdb_data.valid=0 in the next cycle; rr_ptr is unchanged. The cycle after that grants the requester at rr_ptr.
- Counter saturation with CNT_LEN=4: two requesters held valid for 20 cycles -> conflict_count stops at 15.
- Reset mid-stream: reset asserted while all three are valid -> grant=0 during reset; the next cycle has cdb_data.valid=0 and rr_ptr=0. After reset release, requester 0 is granted first.
